// File: rtl/otter_pkg.sv
// Shared decode definitions for the OTTER decode stage: opcodes, control
// encodings and the decoded-control bundle.
package otter_pkg;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpOp     = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } opcode_t;

  // ALU function codes that are not simply {f7[5], f3}
  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluCopy = 4'b1001;

  // Register file write-back source
  localparam logic [1:0] WrSelPc4 = 2'd0;
  localparam logic [1:0] WrSelCsr = 2'd1;
  localparam logic [1:0] WrSelMem = 2'd2;
  localparam logic [1:0] WrSelAlu = 2'd3;

  // ALU operand B source
  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBImmI = 2'd1;
  localparam logic [1:0] SrcBImmS = 2'd2;
  localparam logic [1:0] SrcBImmU = 2'd3;

  // Accepted funct7 values for the OP opcode
  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mext = 7'b0000001;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_fun;
    logic [1:0] rf_wr_sel;
    logic       rf_wr_en;
    logic       mem_write;
    logic       mem_read2;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       mul_en;
    logic [2:0] mul_op;
  } decode_ctrl_t;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StStall = 1'b1
  } dec_state_e;

endpackage

// File: rtl/otter_decode_comb.sv
// Combinational RV32 instruction decoder: instruction word -> control bundle,
// source-register usage flags and sign-extended immediate.
// Optional M-extension decode is enabled by defining OTTER_DECODE_MEXT_EN.
module otter_decode_comb
  import otter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output decode_ctrl_t    ctrl,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic [XLEN-1:0] imm
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic signed [31:0] imm32;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Signed size cast sign-extends to the datapath width
  assign imm = XLEN'(imm32);

  // Opcode decode; illegal encodings suppress every side-effecting control
  always_comb begin
    ctrl           = '0;
    ctrl.rf_wr_sel = WrSelAlu;
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;
    imm32          = '0;
    legal          = 1'b1;

    case (instr[6:0])
      OpLui: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_fun   = AluCopy;
        ctrl.rf_wr_en  = 1'b1;
        imm32          = imm_u;
      end
      OpAuipc: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImmU;
        ctrl.rf_wr_en  = 1'b1;
        imm32          = imm_u;
      end
      OpJal: begin
        ctrl.alu_src_b = SrcBImmI;
        ctrl.rf_wr_sel = WrSelPc4;
        ctrl.rf_wr_en  = 1'b1;
        ctrl.jump      = 1'b1;
        imm32          = imm_j;
      end
      OpJalr: begin
        ctrl.alu_src_b = SrcBImmI;
        ctrl.rf_wr_sel = WrSelPc4;
        ctrl.rf_wr_en  = 1'b1;
        ctrl.jump      = 1'b1;
        rs1_used       = 1'b1;
        imm32          = imm_i;
      end
      OpBranch: begin
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        imm32       = imm_b;
      end
      OpLoad: begin
        ctrl.alu_src_b = SrcBImmI;
        ctrl.rf_wr_sel = WrSelMem;
        ctrl.rf_wr_en  = 1'b1;
        ctrl.mem_read2 = 1'b1;
        rs1_used       = 1'b1;
        imm32          = imm_i;
      end
      OpStore: begin
        ctrl.alu_src_b = SrcBImmS;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        imm32          = imm_s;
      end
      OpImm: begin
        ctrl.alu_src_b = SrcBImmI;
        // Only shifts (f3=101) use instr[30] to pick arithmetic vs logical
        ctrl.alu_fun   = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
        ctrl.rf_wr_en  = 1'b1;
        rs1_used       = 1'b1;
        imm32          = imm_i;
      end
      OpOp: begin
        ctrl.alu_fun  = {instr[30], f3};
        ctrl.rf_wr_en = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        if (f7 == F7Mext) begin
`ifdef OTTER_DECODE_MEXT_EN
          ctrl.mul_en  = 1'b1;
          ctrl.mul_op  = f3;
          ctrl.alu_fun = AluAdd;
`else
          legal = 1'b0;
`endif
        end else if (f7 != F7Base && f7 != F7Alt) begin
          legal = 1'b0;
        end
      end
      OpSystem: begin
        ctrl.alu_fun   = AluCopy;
        ctrl.rf_wr_sel = WrSelCsr;
      end
      default: legal = 1'b0;
    endcase

    if (instr[1:0] != 2'b11) legal = 1'b0;

    ctrl.illegal = ~legal;
    if (!legal) begin
      ctrl.rf_wr_en  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.mem_read2 = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.mul_en    = 1'b0;
    end
  end

endmodule

// File: rtl/otter_decode_stage.sv
// OTTER pipeline decode stage: registers decoded instruction fields and
// controls, applies execute backpressure and flush, and inserts bubbles on a
// load-use dependency. M-extension decode follows OTTER_DECODE_MEXT_EN.
module otter_decode_stage
  import otter_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned RF_ADDR_W        = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_ready,
  input  logic                 ex_ready,
  input  logic                 flush,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_pc,
  output logic [RF_ADDR_W-1:0] id_rs1,
  output logic [RF_ADDR_W-1:0] id_rs2,
  output logic [RF_ADDR_W-1:0] id_rd,
  output logic [XLEN-1:0]      id_imm,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_fun,
  output logic [1:0]           rf_wr_sel,
  output logic                 rf_wr_en,
  output logic                 mem_write,
  output logic                 mem_read2,
  output logic                 branch,
  output logic                 jump,
  output logic                 illegal,
  output logic                 mul_en,
  output logic [2:0]           mul_op
);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      imm;
    decode_ctrl_t         ctrl;
  } id_reg_t;

  localparam bit         HazardEn   = (LOAD_USE_BUBBLES > 0);
  localparam bit         MultiStall = (LOAD_USE_BUBBLES > 1);
  localparam logic [1:0] StallCnt   = MultiStall ? 2'(LOAD_USE_BUBBLES - 1) : 2'd0;

  dec_state_e     state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;
  id_reg_t        id_q, id_d;

  decode_ctrl_t         dec_ctrl;
  logic                 dec_rs1_used, dec_rs2_used;
  logic [XLEN-1:0]      dec_imm;
  logic [RF_ADDR_W-1:0] if_rs1, if_rs2, if_rd;
  logic                 hazard, accept;

  otter_decode_comb #(
    .XLEN(XLEN)
  ) u_decode_comb (
    .instr   (if_instr),
    .ctrl    (dec_ctrl),
    .rs1_used(dec_rs1_used),
    .rs2_used(dec_rs2_used),
    .imm     (dec_imm)
  );

  assign if_rs1 = RF_ADDR_W'(if_instr[19:15]);
  assign if_rs2 = RF_ADDR_W'(if_instr[24:20]);
  assign if_rd  = RF_ADDR_W'(if_instr[11:7]);

  // Load in ID leaving this cycle whose result the offered instruction reads
  assign hazard = HazardEn && valid_q && id_q.ctrl.mem_read2 && (id_q.rd != '0) && ex_ready &&
                  ((dec_rs1_used && (if_rs1 == id_q.rd)) ||
                   (dec_rs2_used && (if_rs2 == id_q.rd)));

  assign if_ready = (state_q == StRun) && !flush && (!valid_q || ex_ready) && !hazard;
  assign accept   = if_valid && if_ready;

  // Next-state: flush first, then stall countdown, then capture/bubble/hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    id_d    = id_q;

    if (flush) begin
      state_d = StRun;
      cnt_d   = 2'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StStall: begin
          if (ex_ready) begin
            valid_d = 1'b0;
            if (cnt_q <= 2'd1) begin
              state_d = StRun;
              cnt_d   = 2'd0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            valid_d   = 1'b1;
            id_d.pc   = if_pc;
            id_d.rs1  = if_rs1;
            id_d.rs2  = if_rs2;
            id_d.rd   = if_rd;
            id_d.imm  = dec_imm;
            id_d.ctrl = dec_ctrl;
          end else if (hazard) begin
            valid_d = 1'b0;
            if (MultiStall) begin
              state_d = StStall;
              cnt_d   = StallCnt;
            end
          end else if (ex_ready) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Pipeline register and FSM state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign id_valid  = valid_q;
  assign id_pc     = id_q.pc;
  assign id_rs1    = id_q.rs1;
  assign id_rs2    = id_q.rs2;
  assign id_rd     = id_q.rd;
  assign id_imm    = id_q.imm;
  assign alu_src_a = id_q.ctrl.alu_src_a;
  assign alu_src_b = id_q.ctrl.alu_src_b;
  assign alu_fun   = id_q.ctrl.alu_fun;
  assign rf_wr_sel = id_q.ctrl.rf_wr_sel;
  assign rf_wr_en  = id_q.ctrl.rf_wr_en;
  assign mem_write = id_q.ctrl.mem_write;
  assign mem_read2 = id_q.ctrl.mem_read2;
  assign branch    = id_q.ctrl.branch;
  assign jump      = id_q.ctrl.jump;
  assign illegal   = id_q.ctrl.illegal;
  assign mul_en    = id_q.ctrl.mul_en;
  assign mul_op    = id_q.ctrl.mul_op;

endmodule

// File: tb/tb_otter_decode_stage.sv
// Scoreboard bench for otter_decode_stage (LOAD_USE_BUBBLES=2): the driver
// queues hand-computed expectations as instructions are accepted, the
// monitor compares each instruction as execute consumes it.
module tb_otter_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        ex_ready = 1'b1;
  logic        flush = 1'b0;

  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        alu_src_a, rf_wr_en, mem_write, mem_read2, branch, jump, illegal, mul_en;
  logic [1:0]  alu_src_b, rf_wr_sel;
  logic [3:0]  alu_fun;
  logic [2:0]  mul_op;

  otter_decode_stage #(
    .XLEN            (32),
    .LOAD_USE_BUBBLES(2),
    .RF_ADDR_W       (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_ready (if_ready),
    .ex_ready (ex_ready),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_rd    (id_rd),
    .id_imm   (id_imm),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_fun  (alu_fun),
    .rf_wr_sel(rf_wr_sel),
    .rf_wr_en (rf_wr_en),
    .mem_write(mem_write),
    .mem_read2(mem_read2),
    .branch   (branch),
    .jump     (jump),
    .illegal  (illegal),
    .mul_en   (mul_en),
    .mul_op   (mul_op)
  );

  always #5 clk = ~clk;

  // Observed ID payload: pc, rs1, rs2, rd, imm, then controls
  logic [97:0] act_w;
  assign act_w = {id_pc, id_rs1, id_rs2, id_rd, id_imm, alu_src_a, alu_src_b, alu_fun,
                  rf_wr_sel, rf_wr_en, mem_write, mem_read2, branch, jump, illegal, mul_en,
                  mul_op};

  logic [97:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] next_pc = 32'h0000_0100;

  task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flags = {rf_wr_en, mem_write, mem_read2, branch, jump, illegal, mul_en}
  function automatic logic [18:0] c(input logic a, input logic [1:0] b, input logic [3:0] f,
                                    input logic [1:0] s, input logic [6:0] flags,
                                    input logic [2:0] mop);
    return {a, b, f, s, flags, mop};
  endfunction

  // Offer one instruction until accepted; report stall cycles and empty-ID cycles seen
  task automatic send(input logic [31:0] instr, input logic [31:0] imm, input logic [18:0] ctl,
                      output int waits, output int zeros, output logic [97:0] e);
    bit got;
    e        = {next_pc, instr[19:15], instr[24:20], instr[11:7], imm, ctl};
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = next_pc;
    waits    = 0;
    zeros    = 0;
    got      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!id_valid) zeros++;
      if (if_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (got) begin
      exp_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got if_ready=0 for 20 cycles expected 1");
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    if_instr = '0;
    next_pc  = next_pc + 32'd4;
  endtask

  // Monitor: compare against the scoreboard whenever execute consumes ID
  initial begin
    logic [97:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", act_w);
        end else begin
          e = exp_q.pop_front();
          chk("decode_out", act_w, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ILw5 = 32'h0001_2283;  // lw  x5,0(x2)
  localparam logic [31:0] IAdd = 32'h0012_8333;  // add x6,x5,x1
  localparam logic [31:0] ILw0 = 32'h0001_2003;  // lw  x0,0(x2)
  localparam logic [31:0] IAd0 = 32'h0010_0333;  // add x6,x0,x1

  initial begin
    int          w, z;
    logic [97:0] e, ea;
    logic [18:0] mul_ctl, lw_ctl, add_ctl;
    logic [31:0] lw_pc;

`ifdef OTTER_DECODE_MEXT_EN
    mul_ctl = c(1'b0, 2'd0, 4'h0, 2'd3, 7'b1000001, 3'b000);
`else
    mul_ctl = c(1'b0, 2'd0, 4'h0, 2'd3, 7'b0000010, 3'b000);
`endif
    lw_ctl  = c(1'b0, 2'd1, 4'h0, 2'd2, 7'b1010000, 3'b000);
    add_ctl = c(1'b0, 2'd0, 4'h0, 2'd3, 7'b1000000, 3'b000);

    // Reset state
    @(posedge clk);
    #1;
    chk("reset_valid", 98'(id_valid), 98'(0));
    chk("reset_outputs", act_w, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 98'(if_ready), 98'(1));
    @(posedge clk);
    #1;

    // addi x1,x0,5 with one-cycle latency
    send(32'h0050_0093, 32'd5, c(1'b0, 2'd1, 4'h0, 2'd3, 7'b1000000, 3'b000), w, z, e);
    @(negedge clk);
    chk("addi_latency", 98'(id_valid), 98'(1));
    @(posedge clk);
    #1;

    // Back-to-back stream of opcode classes
    send(32'hfff0_0093, 32'hffff_ffff, c(1'b0, 2'd1, 4'h0, 2'd3, 7'b1000000, 3'b0), w, z, e);
    send(32'h0051_2423, 32'd8,         c(1'b0, 2'd2, 4'h0, 2'd3, 7'b0100000, 3'b0), w, z, e);
    send(32'hfe20_8ee3, 32'hffff_fffc, c(1'b0, 2'd0, 4'h0, 2'd3, 7'b0001000, 3'b0), w, z, e);
    send(32'h1234_53b7, 32'h1234_5000, c(1'b1, 2'd0, 4'h9, 2'd3, 7'b1000000, 3'b0), w, z, e);
    send(32'h0000_1117, 32'h0000_1000, c(1'b1, 2'd3, 4'h0, 2'd3, 7'b1000000, 3'b0), w, z, e);
    send(32'h0080_00ef, 32'd8,         c(1'b0, 2'd1, 4'h0, 2'd0, 7'b1000100, 3'b0), w, z, e);
    send(32'h0000_8067, 32'd0,         c(1'b0, 2'd1, 4'h0, 2'd0, 7'b1000100, 3'b0), w, z, e);
    send(32'h4030_d213, 32'h0000_0403, c(1'b0, 2'd1, 4'hd, 2'd3, 7'b1000000, 3'b0), w, z, e);
    send(32'h0000_0000, 32'd0,         c(1'b0, 2'd0, 4'h0, 2'd3, 7'b0000010, 3'b0), w, z, e);
    send(32'h0000_0073, 32'd0,         c(1'b0, 2'd0, 4'h9, 2'd1, 7'b0000000, 3'b0), w, z, e);
    send(32'h4020_81b3, 32'd0,         c(1'b0, 2'd0, 4'h8, 2'd3, 7'b1000000, 3'b0), w, z, e);
    send(32'h0220_81b3, 32'd0,         mul_ctl, w, z, e);
    chk("stream_no_stall", 98'(w), 98'(0));

    // Backpressure: ID holds, nothing accepted, nothing lost
    send(32'h0050_0093, 32'd5, c(1'b0, 2'd1, 4'h0, 2'd3, 7'b1000000, 3'b000), w, z, ea);
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_instr = 32'h4020_81b3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("backpressure_hold", {if_ready, id_valid, act_w[95:0]}, {2'b01, ea[95:0]});
      @(posedge clk);
      #1;
    end
    ex_ready = 1'b1;
    send(32'h4020_81b3, 32'd0, c(1'b0, 2'd0, 4'h8, 2'd3, 7'b1000000, 3'b000), w, z, e);

    // Load-use with two bubbles
    send(ILw5, 32'd0, lw_ctl, w, z, e);
    send(IAdd, 32'd0, add_ctl, w, z, e);
    chk("loaduse_ready_low", 98'(w), 98'(2));
    chk("loaduse_bubbles", 98'(z), 98'(2));

    // Load to x0 never stalls
    send(ILw0, 32'd0, lw_ctl, w, z, e);
    send(IAd0, 32'd0, add_ctl, w, z, e);
    chk("x0_no_stall", 98'(w), 98'(0));

    // Flush during a held stall: back to RUN, offered instruction dropped
    send(ILw5, 32'd0, lw_ctl, w, z, e);
    if_valid = 1'b1;
    if_instr = IAdd;
    @(negedge clk);
    chk("hazard_ready", 98'(if_ready), 98'(0));
    @(posedge clk);
    #1;
    ex_ready = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_ready", 98'(if_ready), 98'(0));
    @(posedge clk);
    #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    chk("flush_recover", {id_valid, if_ready}, 98'(2'b01));
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    next_pc  = next_pc + 32'd4;
    send(32'h0050_0093, 32'd5, c(1'b0, 2'd1, 4'h0, 2'd3, 7'b1000000, 3'b000), w, z, e);

    // Asynchronous reset in the middle of a held stall
    lw_pc = next_pc;
    send(ILw5, 32'd0, lw_ctl, w, z, e);
    if_valid = 1'b1;
    if_instr = IAdd;
    @(posedge clk);
    #1;
    ex_ready = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    chk("stall_held", {if_ready, id_valid, id_pc}, {2'b00, lw_pc});
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall_ready", 98'(if_ready), 98'(1));
    chk("rst_stall_valid", 98'(id_valid), 98'(0));
    chk("rst_stall_outputs", act_w, '0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("ready_after_rst_stall", 98'(if_ready), 98'(1));
    @(posedge clk);
    #1;
    next_pc = next_pc + 32'd4;
    send(32'h0050_0093, 32'd5, c(1'b0, 2'd1, 4'h0, 2'd3, 7'b1000000, 3'b000), w, z, e);

    // Drain
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 98'(exp_q.size()), 98'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_decode_stage.md
OTTER_DECODE_STAGE -- requirements
Module: otter_decode_stage

Interface
REQ-001 Parameters SHALL be: XLEN, 32, datapath/immediate width (32 or 64); LOAD_USE_BUBBLES, 1, bubbles inserted on load-use (0..3, 0 = detection off); RF_ADDR_W, 5, register address width.
REQ-002 CLK  in  1  single clock, all state on rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 IF_VALID in 1, IF_INSTR in 32, IF_PC in XLEN: fetched instruction offer; IF_READY out 1: decode accepts this cycle.
REQ-005 EX_READY in 1: execute consumes ID outputs this cycle; FLUSH in 1: kill decode contents (branch taken/trap).
REQ-006 ID_VALID out 1; ID_PC out XLEN; ID_RS1, ID_RS2, ID_RD out RF_ADDR_W; ID_IMM out XLEN: registered instruction fields.
REQ-007 ALU_SRC_A out 1, ALU_SRC_B out 2, ALU_FUN out 4, RF_WR_SEL out 2, RF_WR_EN, MEM_WRITE, MEM_READ2, BRANCH, JUMP, ILLEGAL out 1 each: registered controls.
REQ-008 MUL_EN out 1, MUL_OP out 3: M-extension controls (present in both configurations).

Function
REQ-009 Decode SHALL be combinational from IF_INSTR and captured into the output register on IF_VALID && IF_READY; latency exactly one cycle.
REQ-010 ALU_FUN: OP -> {f7[5],f3}; OP_IMM -> f3==101 ? {f7[5],f3} : {0,f3}; LUI, SYSTEM -> 1001; all else 0000.
REQ-011 RF_WR_SEL: JAL/JALR 0, SYSTEM 1, LOAD 2, else 3; ALU_SRC_A 1 only for LUI/AUIPC; ALU_SRC_B: LOAD/JAL/JALR/OP_IMM 1, STORE 2, AUIPC 3, else 0.
REQ-012 RF_WR_EN=1 for LUI, AUIPC, JAL, JALR, OP, OP_IMM, LOAD; MEM_WRITE=1 only STORE; MEM_READ2=1 only LOAD; BRANCH=1 for BRANCH opcode; JUMP=1 for JAL/JALR.
REQ-013 ID_IMM SHALL be the I/S/B/U/J immediate selected by opcode, sign-extended to XLEN; 0 for OP/SYSTEM.
REQ-014 ILLEGAL=1 when instr[1:0]!=11, opcode unlisted, or OP with f7 not 0000000/0100000 (or 0000001 when M enabled); illegal forces RF_WR_EN, MEM_WRITE, MEM_READ2, BRANCH, JUMP, MUL_EN to 0.
REQ-015 IF_READY SHALL equal state==RUN && !FLUSH && (!ID_VALID || EX_READY) && !hazard.
REQ-016 hazard SHALL be ID_VALID && MEM_READ2 && ID_RD!=0 && EX_READY && LOAD_USE_BUBBLES>0 && (rs1 used && rs1==ID_RD || rs2 used && rs2==ID_RD); rs1 used by JALR/BRANCH/LOAD/STORE/OP_IMM/OP, rs2 by BRANCH/STORE/OP.
REQ-017 States RUN, STALL; on hazard ID_VALID<=0 and, if LOAD_USE_BUBBLES>1, go STALL with cnt<=LOAD_USE_BUBBLES-1, else stay RUN.
REQ-018 In STALL each EX_READY cycle decrements cnt and keeps ID_VALID=0; transition to RUN when cnt reaches 0.
REQ-019 When EX_READY=1 and nothing accepted, ID_VALID<=0; when EX_READY=0 all outputs hold unchanged.
REQ-020 FLUSH SHALL have top priority: next cycle ID_VALID=0, state RUN, cnt 0; concurrent IF_VALID instruction dropped.

Reset
REQ-021 RST_N low SHALL immediately force state RUN, cnt 0, ID_VALID 0 and every other output register to 0, including mid-stall.
REQ-022 IF_READY SHALL be 1 in the first cycle after RST_N deasserts.

Configuration
REQ-023 Macro OTTER_DECODE_MEXT_EN defined: OP with f7=0000001 gives MUL_EN=1, MUL_OP=f3, RF_WR_EN=1, ALU_FUN=0000.
REQ-024 Macro undefined: MUL_EN, MUL_OP tied 0; f7=0000001 OP is ILLEGAL.

Structure
REQ-025 Shared package otter_pkg SHALL hold opcode_t enum, ALU_FUN/RF_WR_SEL/ALU_SRC_B encodings and decode_ctrl_t struct.
REQ-026 Combinational decode SHALL be sub-module otter_decode_comb (IF_INSTR -> decode_ctrl_t + immediate); this module holds register, FSM, hazard logic.

Verification
REQ-027 Reset: assert RST_N=0 during STALL -> ID_VALID=0, state RUN immediately; IF_READY=1 cycle after release.
REQ-028 Decode: 0x00500093 (addi x1,x0,5) -> next cycle ID_VALID=1, ID_RD=1, ID_IMM=5, ALU_SRC_B=1, ALU_FUN=0000, RF_WR_EN=1, RF_WR_SEL=3.
REQ-029 Load-use, LOAD_USE_BUBBLES=2: 0x00012283 then 0x00128333, EX_READY=1 -> IF_READY low 2 cycles, two ID_VALID=0 cycles, add issued third cycle; with rd=x0 no stall.
REQ-030 Backpressure: EX_READY=0 for 3 cycles with ID_VALID=1 -> outputs stable, IF_READY=0, no instruction lost.
REQ-031 FLUSH=1 with IF_VALID=1 during STALL -> next cycle ID_VALID=0, state RUN, instruction not captured.
REQ-032 0x022081b3 (mul x3,x1,x2): macro on -> MUL_EN=1, MUL_OP=000, RF_WR_EN=1; macro off -> ILLEGAL=1, RF_WR_EN=0.
